// File: rtl/load_store_unit.sv
// Load/store unit: computes base+offset, checks alignment, range and funct3 legality,
// and performs a single one-cycle access to a RAM controller before returning a response.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wData,
  output logic [2:0]  ram_control,
  input  logic [31:0] ram_rData,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned DW = 32;
  localparam logic [DW:0] ADDR_LIMIT = (DW+1)'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t          state;
  logic [DW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [2:0]      funct3_q;
  logic            we_q;

  logic [2:0]      ctl_c;
  logic            illegal_c;
  logic            misalign_c;
  logic            range_err_c;
  logic            err_c;

  // Ready is gated by reset so it is low for the whole time reset is held.
  assign req_ready = (state == S_IDLE) && reset;

  // Decode of the latched request: controller size code and error conditions.
  always_comb begin
    ctl_c       = 3'b000;
    illegal_c   = 1'b0;
    misalign_c  = 1'b0;
    range_err_c = 1'b0;
    case (funct3_q)
      3'b000:  ctl_c = 3'b001;
      3'b001:  ctl_c = 3'b010;
      3'b010:  ctl_c = 3'b000;
      3'b100:  ctl_c = 3'b101;
      3'b101:  ctl_c = 3'b110;
      default: illegal_c = 1'b1;
    endcase
    if (we_q && (funct3_q == 3'b100 || funct3_q == 3'b101)) illegal_c = 1'b1;
    if ((funct3_q == 3'b001 || funct3_q == 3'b101) && addr_q[0]) misalign_c = 1'b1;
    if (funct3_q == 3'b010 && addr_q[1:0] != 2'b00) misalign_c = 1'b1;
    range_err_c = {1'b0, addr_q} >= ADDR_LIMIT;
    err_c = illegal_c || misalign_c || range_err_c;
  end

  // Request FSM; RAM-side outputs only change on entry to ACCESS so they stay glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wData   <= '0;
      ram_control <= 3'b000;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
    end else begin
      ram_we     <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_base + req_offset;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (err_c) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
            state      <= S_RESP;
          end else begin
            ram_addr    <= addr_q;
            ram_control <= ctl_c;
            ram_wData   <= wdata_q;
            ram_we      <= we_q;
            state       <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_data  <= we_q ? '0 : ram_rData;
          state      <= S_RESP;
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/back-to-back sequences,
// and randomized requests checked against a byte-level memory model.
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wData;
  logic [2:0]  ram_control;
  logic [31:0] ram_rData;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wData(ram_wData),
    .ram_control(ram_control), .ram_rData(ram_rData),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Downstream RAM controller: lane insertion on write, extension on read.
  logic [7:0] ram [1024];
  logic [9:0] ra;
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    ra = ram_addr[9:0];
    b0 = ram[ra];
    b1 = ram[ra + 10'd1];
    b2 = ram[ra + 10'd2];
    b3 = ram[ra + 10'd3];
    case (ram_control)
      3'b000:  ram_rData = {b3, b2, b1, b0};
      3'b001:  ram_rData = {{24{b0[7]}}, b0};
      3'b010:  ram_rData = {{16{b1[7]}}, b1, b0};
      3'b101:  ram_rData = {24'h0, b0};
      3'b110:  ram_rData = {16'h0, b1, b0};
      default: ram_rData = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (ram_we) begin
      ram[ra] <= ram_wData[7:0];
      if (ram_control == 3'b010 || ram_control == 3'b000) ram[ra + 10'd1] <= ram_wData[15:8];
      if (ram_control == 3'b000) begin
        ram[ra + 10'd2] <= ram_wData[23:16];
        ram[ra + 10'd3] <= ram_wData[31:24];
      end
    end
  end

  // Reference model: byte-addressed shadow memory and the architectural access rules.
  logic [7:0] ref_mem [1024];

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic err, output logic [31:0] data);
    int size;
    logic sgn;
    logic [63:0] v;
    err = 1'b0; data = 32'h0; sgn = 1'b0; v = 64'h0; size = 1;
    case (f3)
      3'b000: begin size = 1; sgn = 1'b1; end
      3'b001: begin size = 2; sgn = 1'b1; end
      3'b010: size = 4;
      3'b100: size = 1;
      3'b101: size = 2;
      default: err = 1'b1;
    endcase
    if (we && (f3 == 3'b100 || f3 == 3'b101)) err = 1'b1;
    if ((64'(a) % 64'(size)) != 64'h0) err = 1'b1;
    if (64'(a) >= 64'(4 * MEM_WORDS)) err = 1'b1;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
        if (sgn && v[8*size-1]) v = v | ({64{1'b1}} << (8 * size));
        data = v[31:0];
      end
    end
  endfunction

  function automatic logic [2:0] exp_ctl(input logic [2:0] f3);
    case (f3)
      3'b000:  return 3'b001;
      3'b001:  return 3'b010;
      3'b010:  return 3'b000;
      3'b100:  return 3'b101;
      3'b101:  return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One complete request; caller is positioned just after a clock edge with the unit idle.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] off, input logic [31:0] wd, input logic use_tbl,
                        input logic tbl_err, input logic [31:0] tbl_data, input string nm);
    logic [31:0] a, mdata, edata, rdata, cap_addr, cap_wd;
    logic merr, eerr, got, rerr;
    int n, we_cnt, lat;
    a = base + off;
    model(we, f3, a, wd, merr, mdata);
    eerr  = use_tbl ? tbl_err  : merr;
    edata = use_tbl ? tbl_data : mdata;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 10) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      check({nm, ".ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Hostile inputs while busy must not be picked up.
    req_we = 1'b1; req_funct3 = 3'b010;
    req_base = $urandom & 32'h0000_03FC; req_offset = 32'h0; req_wdata = $urandom;
    we_cnt = 0; got = 1'b0; lat = 0; rerr = 1'b0; rdata = 32'h0; cap_addr = 32'h0; cap_wd = 32'h0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(posedge clk); #1;
      if (ram_we) begin we_cnt++; cap_addr = ram_addr; cap_wd = ram_wData; end
      if (c == 1 && !eerr) begin
        check({nm, ".ram_addr"}, ram_addr, a);
        check({nm, ".ram_control"}, 32'(ram_control), 32'(exp_ctl(f3)));
      end
      if (resp_valid) begin got = 1'b1; lat = c + 1; rerr = resp_err; rdata = resp_data; end
    end
    req_valid = 1'b0;
    check({nm, ".resp_seen"}, 32'(got), 32'd1);
    check({nm, ".err"}, 32'(rerr), 32'(eerr));
    check({nm, ".data"}, rdata, edata);
    check({nm, ".latency"}, 32'(lat), eerr ? 32'd2 : 32'd3);
    check({nm, ".we_pulses"}, 32'(we_cnt), (we && !eerr) ? 32'd1 : 32'd0);
    if (we_cnt == 1) begin
      check({nm, ".we_addr"}, cap_addr, a);
      check({nm, ".we_wdata"}, cap_wd, wd);
    end
    @(posedge clk); #1;
    check({nm, ".pulse_end"}, 32'(resp_valid), 32'd0);
    check({nm, ".ready_again"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] wd;
    logic        err;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] base,
                     input logic [31:0] off, input logic [31:0] wd, input logic err,
                     input logic [31:0] data);
    vec_t v;
    v.we = we; v.f3 = f3; v.base = base; v.off = off; v.wd = wd; v.err = err; v.data = data;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] bb_off [3];
    logic [2:0]  bb_f3 [3];
    logic [31:0] bb_exp [3];
    int ac[$], rc[$];
    logic [31:0] rdat[$];
    logic rd [24];
    logic rdy, e_err, exp_rdy;
    int k, bad;

    for (int i = 0; i < 1024; i++) begin ram[i] = 8'h0; ref_mem[i] = 8'h0; end
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_base = 32'h0; req_offset = 32'h0; req_wdata = 32'h0;

    // Reset state.
    #12;
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.ram_we", 32'(ram_we), 32'd0);
    check("rst.ram_addr", ram_addr, 32'h0);
    check("rst.ram_wData", ram_wData, 32'h0);
    check("rst.ram_control", 32'(ram_control), 32'd0);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    check("rst.resp_data", resp_data, 32'h0);
    @(negedge clk); reset = 1'b1;

    //   we    f3      base           off            wdata          err   data
    add(1'b1, 3'b010, 32'h0000_0010, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0);
    add(1'b0, 3'b010, 32'h0000_0010, 32'h0000_0004, 32'h0,         1'b0, 32'hDEAD_BEEF);
    add(1'b1, 3'b000, 32'h0000_0020, 32'h0000_0001, 32'h1234_5680, 1'b0, 32'h0);
    add(1'b0, 3'b000, 32'h0000_0020, 32'h0000_0001, 32'h0,         1'b0, 32'hFFFF_FF80);
    add(1'b0, 3'b100, 32'h0000_0020, 32'h0000_0001, 32'h0,         1'b0, 32'h0000_0080);
    add(1'b0, 3'b001, 32'h0000_0014, 32'h0000_0000, 32'h0,         1'b0, 32'hFFFF_BEEF);
    add(1'b0, 3'b101, 32'h0000_0016, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_DEAD);
    add(1'b0, 3'b010, 32'h0000_0020, 32'h0000_0002, 32'h0,         1'b1, 32'h0);
    add(1'b1, 3'b001, 32'h0000_0023, 32'h0000_0000, 32'h0000_FFFF, 1'b1, 32'h0);
    add(1'b0, 3'b010, 32'h0000_0400, 32'h0000_0000, 32'h0,         1'b1, 32'h0);
    add(1'b0, 3'b011, 32'h0000_0010, 32'h0000_0000, 32'h0,         1'b1, 32'h0);
    add(1'b1, 3'b100, 32'h0000_0010, 32'h0000_0000, 32'h55,        1'b1, 32'h0);
    add(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'hCAFE_F00D, 1'b0, 32'h0);
    add(1'b0, 3'b010, 32'h0000_0004, 32'h0000_0000, 32'h0,         1'b0, 32'hCAFE_F00D);
    add(1'b1, 3'b010, 32'h0000_0400, 32'hFFFF_FFFC, 32'h1122_3344, 1'b0, 32'h0);
    add(1'b0, 3'b010, 32'h0000_03FC, 32'h0000_0000, 32'h0,         1'b0, 32'h1122_3344);
    add(1'b0, 3'b100, 32'h0000_03FF, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0011);
    add(1'b0, 3'b001, 32'h0000_0001, 32'h0000_0000, 32'h0,         1'b1, 32'h0);
    add(1'b0, 3'b110, 32'h0000_0010, 32'h0000_0000, 32'h0,         1'b1, 32'h0);
    add(1'b1, 3'b101, 32'h0000_0010, 32'h0000_0000, 32'h0,         1'b1, 32'h0);
    add(1'b0, 3'b010, 32'h0000_0014, 32'h0000_0000, 32'h0,         1'b0, 32'hDEAD_BEEF);
    add(1'b1, 3'b001, 32'h0000_0020, 32'h0000_0000, 32'hABCD_7777, 1'b0, 32'h0);
    add(1'b0, 3'b010, 32'h0000_0030, 32'hFFFF_FFF0, 32'h0,         1'b0, 32'h0000_7777);

    // First vector is driven straight from the release edge.
    foreach (tbl[i])
      do_req(tbl[i].we, tbl[i].f3, tbl[i].base, tbl[i].off, tbl[i].wd, 1'b1,
             tbl[i].err, tbl[i].data, $sformatf("vec%0d", i));

    // Reset pulled during CHECK of a store: immediate abort, memory untouched.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h40; req_offset = 32'h0; req_wdata = 32'h55AA_55AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("abort.req_ready", 32'(req_ready), 32'd0);
    check("abort.ram_we", 32'(ram_we), 32'd0);
    check("abort.ram_addr", ram_addr, 32'h0);
    check("abort.ram_wData", ram_wData, 32'h0);
    check("abort.ram_control", 32'(ram_control), 32'd0);
    check("abort.resp_valid", 32'(resp_valid), 32'd0);
    check("abort.resp_err", 32'(resp_err), 32'd0);
    check("abort.resp_data", resp_data, 32'h0);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (ram_we || resp_valid) bad++;
    end
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (ram_we || resp_valid) bad++;
    end
    check("abort.no_activity", 32'(bad), 32'd0);
    check("abort.ready_after", 32'(req_ready), 32'd1);
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "abort.mem_untouched");

    // Back-to-back requests with req_valid held high.
    bb_off[0] = 32'h14;  bb_f3[0] = 3'b010;
    bb_off[1] = 32'h3FC; bb_f3[1] = 3'b010;
    bb_off[2] = 32'h21;  bb_f3[2] = 3'b100;
    for (int i = 0; i < 3; i++) model(1'b0, bb_f3[i], bb_off[i], 32'h0, e_err, bb_exp[i]);
    k = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = bb_f3[0];
    req_base = 32'h0; req_offset = bb_off[0]; req_wdata = 32'h0;
    rdy = req_ready;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      if (rdy && req_valid) begin ac.push_back(c); k++; end
      #1;
      if (k < 3) begin req_funct3 = bb_f3[k]; req_offset = bb_off[k]; end
      else req_valid = 1'b0;
      if (resp_valid) begin rc.push_back(c); rdat.push_back(resp_data); end
      rdy = req_ready;
      rd[c] = req_ready;
    end
    check("b2b.accepts", 32'(ac.size()), 32'd3);
    check("b2b.pulses", 32'(rc.size()), 32'd3);
    if (ac.size() == 3 && rc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("b2b.resp_cycle%0d", i), 32'(rc[i] - ac[i]), 32'd2);
        check($sformatf("b2b.data%0d", i), rdat[i], bb_exp[i]);
      end
      check("b2b.spacing01", 32'(rc[1] - rc[0]), 32'd4);
      check("b2b.spacing12", 32'(rc[2] - rc[1]), 32'd4);
    end
    bad = 0;
    for (int c = 0; c < 24; c++) begin
      exp_rdy = 1'b1;
      foreach (ac[j]) if (c >= ac[j] && c <= ac[j] + 2) exp_rdy = 1'b0;
      if (rd[c] !== exp_rdy) bad++;
    end
    check("b2b.ready_pattern", 32'(bad), 32'd0);

    // Randomized requests against the model.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] rb, ro;
      rb = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1100));
      ro = 32'($urandom_range(0, 32)) - 32'd16;
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rb, ro, $urandom,
             1'b0, 1'b0, 32'h0, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low, with ports named clk and reset.
REQ-002 MEM_WORDS, default 256, SHALL be the number of 32-bit words in the downstream RAM; the valid byte range is 0 .. 4*MEM_WORDS-1.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  core presents a memory request.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RISC-V funct3 of the load or store.
REQ-009 req_base  input  32  rs1 value.
REQ-010 req_offset  input  32  sign-extended immediate.
REQ-011 req_wdata  input  32  rs2 value, used for stores.
REQ-012 ram_we  output  1  write enable to the RAM controller.
REQ-013 ram_addr  output  32  byte address to the RAM controller.
REQ-014 ram_wData  output  32  store data to the RAM controller; unshifted, because the controller performs lane insertion.
REQ-015 ram_control  output  3  access-size code sent to the RAM controller.
REQ-016 ram_rData  input  32  already-extended load data from the RAM controller; combinational read.
REQ-017 resp_valid  output  1  one-cycle completion pulse.
REQ-018 resp_data  output  32  load result; 0 for stores and for errors.
REQ-019 resp_err  output  1  qualifies resp_valid; marks a misaligned, out-of-range or illegal access.

Function
REQ-020 The FSM SHALL have four states: IDLE, CHECK, ACCESS and RESP.
REQ-021 req_ready SHALL equal 1 exactly when the state is IDLE and reset is high.
REQ-022 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-023 On acceptance the unit SHALL register: addr = req_base + req_offset (modulo 2^32, carry discarded), req_we, req_funct3 and req_wdata; the state then goes to CHECK.
REQ-024 Inputs SHALL be ignored whenever the state is not IDLE.
REQ-025 The ram_control mapping SHALL be: funct3 000→001, 001→010, 010→000, 100→101, 101→110.
REQ-026 Illegal accesses SHALL be: funct3 011, 110 or 111; or a store (req_we=1) with funct3 100 or 101.
REQ-027 Misaligned accesses SHALL be: halfword (001/101) with addr[0]=1; word (010) with addr[1:0]≠00.
REQ-028 An out-of-range access SHALL be one with addr ≥ 4*MEM_WORDS.
REQ-029 In CHECK, if any error of REQ-026..028 holds, the unit SHALL go to RESP with the error flag set; otherwise it SHALL go to ACCESS.
REQ-030 In ACCESS, ram_addr and ram_control SHALL be driven from the registered values for exactly one cycle.
REQ-031 In ACCESS, a store SHALL drive ram_we=1 for exactly one cycle and ram_wData = registered wdata.
REQ-032 In ACCESS, a load SHALL keep ram_we=0 and capture ram_rData into the result register at the end of the cycle.
REQ-033 The unit SHALL then go to RESP.
REQ-034 ram_we SHALL be 0 in every state other than ACCESS, and 0 for errored requests.
REQ-035 In RESP, resp_valid SHALL be 1 for exactly one cycle, with resp_err and resp_data stable; the state then returns to IDLE.
REQ-036 Latency for a request accepted on edge T: resp_valid SHALL be high in cycle T+3 for a successful access and T+2 for an errored one.
REQ-037 The maximum throughput SHALL be one request per 4 cycles; back-to-back requests SHALL be accepted on the edge following RESP.
REQ-038 Outside ACCESS, ram_addr and ram_control SHALL hold their last registered values, which keeps them glitch-free; ram_wData SHALL do the same.
REQ-039 Address wrap (for example 0xFFFFFFFC + 8 = 0x00000004) SHALL be legal and in range.

Reset
REQ-040 While reset=0, regardless of clk: state=IDLE, req_ready=0, ram_we=0, ram_addr=0, ram_wData=0, ram_control=000, resp_valid=0, resp_err=0, resp_data=0.
REQ-041 Reset asserted mid-operation SHALL abort the operation immediately: no ram_we pulse and no resp_valid.
REQ-042 The first request SHALL be acceptable on the first rising edge after reset deasserts.

Verification
REQ-043 Scenario — SW then LW: SW base=0x10, off=4, wdata=0xDEADBEEF → ram_we=1 in one cycle with ram_addr=0x14 and ram_control=000; a following LW of 0x14 → resp_data=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after accept.
REQ-044 Scenario — sub-word loads: SB 0x80 to 0x21, then LB of 0x21 → 0xFFFFFF80 with ram_control=001, and LBU of 0x21 → 0x00000080 with ram_control=101.
REQ-045 Scenario — misaligned accesses: LW addr 0x22 → resp_err=1, no ACCESS cycle, resp_valid 2 cycles after accept; SH addr 0x23 → resp_err=1 and ram_we never asserted.
REQ-046 Scenario — range and illegal code: with MEM_WORDS=256, LW 0x400 → resp_err=1; funct3=011 → resp_err=1; store with funct3=100 → resp_err=1.
REQ-047 Scenario — reset during a store: reset pulled low during CHECK of an SW → all outputs go to reset values asynchronously, no ram_we pulse, and req_ready=1 one cycle after release.
REQ-048 Scenario — back-to-back requests: req_valid held high with 3 consecutive requests → exactly 3 resp_valid pulses 4 cycles apart, and req_ready low except in IDLE.
